// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if: cache coherence ports and memory port bundled for the snoop-bus controller
interface coherence_bus_ctrl_if #(
    parameter int NCACHES    = 2,
    parameter int BLOCK_SIZE = 2
);
    localparam int BW = 32 * BLOCK_SIZE;
    logic [NCACHES-1:0]    req;
    logic [NCACHES-1:0]    req_write;
    logic [NCACHES*32-1:0] req_addr;
    logic [NCACHES-1:0]    snoop_req;
    logic [31:0]           snoop_addr;
    logic                  snoop_inv;
    logic [NCACHES-1:0]    snoop_busy;
    logic [NCACHES-1:0]    snoop_hit;
    logic [NCACHES-1:0]    snoop_dirty;
    logic [NCACHES*BW-1:0] snoop_data;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [31:0]           mem_addr;
    logic [BW-1:0]         mem_wdata;
    logic [BW-1:0]         mem_rdata;
    logic                  mem_ready;
    logic [NCACHES-1:0]    resp_valid;
    logic [BW-1:0]         resp_data;
    logic [1:0]            resp_state;

    modport master (
        input  req, req_write, req_addr, snoop_busy, snoop_hit, snoop_dirty, snoop_data,
               mem_rdata, mem_ready,
        output snoop_req, snoop_addr, snoop_inv, mem_ren, mem_wen, mem_addr, mem_wdata,
               resp_valid, resp_data, resp_state
    );

    modport slave (
        output req, req_write, req_addr, snoop_busy, snoop_hit, snoop_dirty, snoop_data,
               mem_rdata, mem_ready,
        input  snoop_req, snoop_addr, snoop_inv, mem_ren, mem_wen, mem_addr, mem_wdata,
               resp_valid, resp_data, resp_state
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: round-robin MESI snoop-bus controller between private L1 caches and memory
module coherence_bus_ctrl #(
    parameter int NCACHES    = 2,
    parameter int BLOCK_SIZE = 2
) (
    input  logic CLK,
    input  logic nRST,
    coherence_bus_ctrl_if.master bus
);
    localparam int BW  = 32 * BLOCK_SIZE;
    localparam int IW  = $clog2(NCACHES);
    localparam int OFF = $clog2(BLOCK_SIZE) + 2;
    localparam logic [31:0] MASK = ~((32'd1 << OFF) - 32'd1);
    localparam logic [1:0] MODIFIED = 2'd0, EXCLUSIVE = 2'd1, SHARED = 2'd2, INVALID = 2'd3;

    typedef enum logic [2:0] {IDLE, SNOOP, COLLECT, MEMRD, WB, DONE} state_t;

    state_t          state, next;
    logic [IW-1:0]   last, idx, grant, resp_idx;
    logic            found, hit_any, others_busy, write, shared, snoop_go;
    logic [31:0]     addr;
    logic [BW-1:0]   data;
    logic [1:0]      end_state;

    // round-robin pick: first pending request after the last one served
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= NCACHES; i++) begin
            if (!found && bus.req[(int'(last) + i) % NCACHES]) begin
                grant = IW'((int'(last) + i) % NCACHES);
                found = 1'b1;
            end
        end
    end

    // lowest-index hitter and busy status, both excluding the requester
    always_comb begin
        resp_idx    = '0;
        hit_any     = 1'b0;
        others_busy = 1'b0;
        for (int i = NCACHES - 1; i >= 0; i--) begin
            if (bus.snoop_hit[i] && i != int'(idx)) begin
                resp_idx = IW'(i);
                hit_any  = 1'b1;
            end
            if (bus.snoop_busy[i] && i != int'(idx)) others_busy = 1'b1;
        end
    end

    // state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else state <= next;
    end

    // next-state sequencing of one transaction at a time
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = found ? SNOOP : IDLE;
            SNOOP:   next = others_busy ? SNOOP : COLLECT;
            COLLECT: next = !hit_any ? MEMRD : (bus.snoop_dirty[resp_idx] ? WB : DONE);
            MEMRD:   next = bus.mem_ready ? DONE : MEMRD;
            WB:      next = bus.mem_ready ? DONE : WB;
            default: next = IDLE;
        endcase
    end

    // transaction context: requester, aligned address, block data and sharing outcome
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last   <= IW'(NCACHES - 1);
            idx    <= '0;
            addr   <= '0;
            write  <= 1'b0;
            shared <= 1'b0;
            data   <= '0;
        end else begin
            if (state == IDLE && found) begin
                idx   <= grant;
                addr  <= bus.req_addr[int'(grant)*32 +: 32] & MASK;
                write <= bus.req_write[grant];
            end
            if (state == COLLECT) begin
                shared <= hit_any;
                if (hit_any) data <= bus.snoop_data[int'(resp_idx)*BW +: BW];
            end
            if (state == MEMRD && bus.mem_ready) data <= bus.mem_rdata;
            if (state == DONE) last <= idx;
        end
    end

    assign snoop_go   = state == SNOOP && !others_busy;
    assign end_state  = write ? MODIFIED : (shared ? SHARED : EXCLUSIVE);

    assign bus.snoop_req  = snoop_go ? ~(NCACHES'(1) << idx) : '0;
    assign bus.snoop_addr = snoop_go ? addr : '0;
    assign bus.snoop_inv  = snoop_go && write;
    assign bus.mem_ren    = state == MEMRD;
    assign bus.mem_wen    = state == WB;
    assign bus.mem_addr   = (state == MEMRD || state == WB) ? addr : '0;
    assign bus.mem_wdata  = state == WB ? data : '0;
    assign bus.resp_valid = state == DONE ? NCACHES'(1) << idx : '0;
    assign bus.resp_data  = state == DONE ? data : '0;
    assign bus.resp_state = state == DONE ? end_state : INVALID;
endmodule
